// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with normal or show-ahead read mode.
// Provides almost-full/empty thresholds, sticky error flags and a synchronous flush.
module sync_fifo_param #(
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 256,
  parameter  int AFULL_TH   = DEPTH - 4,
  parameter  int AEMPTY_TH  = 4,
  parameter  int SHOW_AHEAD = 0,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sclr,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] pi_date,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic [DATA_W-1:0] po_date,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   usedw,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_ok;
  logic              wr_ok;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W:0]   usedw_nxt;

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  assign rd_ok  = rd_req & ~empty;
  assign wr_ok  = wr_req & (~full | rd_ok);
  assign rd_acc = rd_ok & ~sclr;
  assign wr_acc = wr_ok & ~sclr;

  always_comb begin
    usedw_nxt = usedw;
    if (sclr)
      usedw_nxt = '0;
    else if (wr_acc && !rd_acc)
      usedw_nxt = usedw + (ADDR_W+1)'(1);
    else if (rd_acc && !wr_acc)
      usedw_nxt = usedw - (ADDR_W+1)'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AFULL_TH == 0);
    end else begin
      if (sclr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      usedw        <= usedw_nxt;
      empty        <= (usedw_nxt == '0);
      full         <= (usedw_nxt == FULL_CNT);
      almost_empty <= (usedw_nxt <= AEMPTY_CNT);
      almost_full  <= (usedw_nxt >= AFULL_CNT);
    end
  end

  // A new error in the same cycle as clr_err wins, so no event is lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (sclr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_req && !wr_ok)
        ovf <= 1'b1;
      else if (clr_err)
        ovf <= 1'b0;
      if (rd_req && !rd_ok)
        udf <= 1'b1;
      else if (clr_err)
        udf <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_acc)
      mem[wr_ptr] <= pi_date;
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign po_date = mem[rd_ptr];
    end else begin : g_normal
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
          po_date <= '0;
        else if (rd_acc)
          po_date <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench: default normal-mode FIFO plus a 4-deep show-ahead FIFO.
module tb_sync_fifo_param;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;

  logic       b_sclr = 1'b0, b_clr = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [8:0] b_usedw;

  logic       s_sclr = 1'b0, s_clr = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic [7:0] s_din = '0, s_dout;
  logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
  logic [2:0] s_usedw;

  int errors = 0;
  int checks = 0;

  logic [7:0] bq[$];
  logic [7:0] sq[$];
  logic [7:0] b_exp_po = '0;
  logic [1:0] mix_ops [20];

  always #5 sys_clk = ~sys_clk;

  sync_fifo_param u_big (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sclr(b_sclr), .clr_err(b_clr),
    .pi_date(b_din), .wr_req(b_wr), .rd_req(b_rd), .po_date(b_dout),
    .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
    .usedw(b_usedw), .ovf(b_ovf), .udf(b_udf)
  );

  sync_fifo_param #(.DEPTH(4), .SHOW_AHEAD(1)) u_small (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sclr(s_sclr), .clr_err(s_clr),
    .pi_date(s_din), .wr_req(s_wr), .rd_req(s_rd), .po_date(s_dout),
    .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
    .usedw(s_usedw), .ovf(s_ovf), .udf(s_udf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on the 256-deep FIFO; the queue tracks what should be stored.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d,
                               input logic clr, input logic sc);
    logic r_ok, w_ok;
    b_wr = wr; b_rd = rd; b_din = d; b_clr = clr; b_sclr = sc;
    r_ok = rd & (bq.size() != 0) & !sc;
    w_ok = wr & ((bq.size() < 256) | r_ok) & !sc;
    @(posedge sys_clk);
    if (sc) bq.delete();
    else begin
      if (r_ok) b_exp_po = bq.pop_front();
      if (w_ok) bq.push_back(d);
    end
    #1;
    b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_sclr = 1'b0;
  endtask

  task automatic applySmallStimulus(input logic wr, input logic rd, input logic [7:0] d);
    logic r_ok, w_ok;
    s_wr = wr; s_rd = rd; s_din = d;
    r_ok = rd & (sq.size() != 0);
    w_ok = wr & ((sq.size() < 4) | r_ok);
    @(posedge sys_clk);
    if (r_ok) void'(sq.pop_front());
    if (w_ok) sq.push_back(d);
    #1;
    s_wr = 1'b0; s_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mix_ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01,
                2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};

    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("rst_usedw", b_usedw, 0);
    checkOutput("rst_empty", b_empty, 1);
    checkOutput("rst_full", b_full, 0);
    checkOutput("rst_ae", b_ae, 1);
    checkOutput("rst_af", b_af, 0);
    checkOutput("rst_ovf", b_ovf, 0);
    checkOutput("rst_udf", b_udf, 0);
    checkOutput("rst_po", b_dout, 0);
    checkOutput("rst_small_af_th0", s_af, 1);
    checkOutput("rst_small_empty", s_empty, 1);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Five writes then five reads, normal mode
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    checkOutput("five_usedw", b_usedw, 5);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checkOutput("five_po", b_dout, i);
      checkOutput("five_usedw_dn", b_usedw, 5 - i);
      checkOutput("five_empty", b_empty, (i == 5));
    end

    // Fill to 256 and overflow
    for (int j = 0; j < 256; j++) begin
      applyStimulus(1'b1, 1'b0, 8'(j), 1'b0, 1'b0);
      if (j == 250 || j == 251) checkOutput("af_edge", b_af, (j == 251));
    end
    checkOutput("fill_usedw", b_usedw, 256);
    checkOutput("fill_full", b_full, 1);
    checkOutput("fill_ovf_pre", b_ovf, 0);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    checkOutput("ovf_set", b_ovf, 1);
    checkOutput("ovf_usedw", b_usedw, 256);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ovf_clr", b_ovf, 0);

    // Simultaneous read and write while full
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
      checkOutput("fullrw_po", b_dout, i);
      checkOutput("fullrw_usedw", b_usedw, 256);
      checkOutput("fullrw_full", b_full, 1);
    end
    checkOutput("fullrw_ovf", b_ovf, 0);
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checkOutput("drain_po", b_dout, b_exp_po);
    end
    checkOutput("drain_last", b_dout, 8'h89);
    checkOutput("drain_empty", b_empty, 1);
    checkOutput("drain_usedw", b_usedw, 0);

    // Read and write together while empty
    applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("udf_set", b_udf, 1);
    checkOutput("udf_usedw", b_usedw, 1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("udf_read_po", b_dout, 8'hA5);
    checkOutput("udf_sticky", b_udf, 1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_clr_vs_new", b_udf, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_clr", b_udf, 0);

    // Flush with concurrent write
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0, 1'b0);
    checkOutput("sclr_pre_usedw", b_usedw, 3);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
    checkOutput("sclr_usedw", b_usedw, 0);
    checkOutput("sclr_empty", b_empty, 1);
    checkOutput("sclr_ovf", b_ovf, 0);
    checkOutput("sclr_po_hold", b_dout, 8'hA5);

    // Show-ahead FIFO, DEPTH=4
    applySmallStimulus(1'b1, 1'b0, 8'h11);
    checkOutput("sa_first_po", s_dout, 8'h11);
    checkOutput("sa_first_empty", s_empty, 0);
    applySmallStimulus(1'b1, 1'b0, 8'h22);
    checkOutput("sa_head_hold", s_dout, 8'h11);
    applySmallStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("sa_next_po", s_dout, 8'h22);
    checkOutput("sa_usedw", s_usedw, 1);
    for (int i = 0; i < 20; i++) begin
      applySmallStimulus(mix_ops[i][1], mix_ops[i][0], 8'h30 + 8'(i));
      checkOutput("sa_mix_usedw", s_usedw, sq.size());
      checkOutput("sa_mix_empty", s_empty, (sq.size() == 0));
      if (sq.size() != 0) checkOutput("sa_mix_po", s_dout, sq[0]);
    end
    checkOutput("sa_ovf", s_ovf, 1);
    checkOutput("sa_udf", s_udf, 1);

    // Asynchronous reset in the middle of a write burst
    applyStimulus(1'b1, 1'b0, 8'h61, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h62, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("burst_po", b_dout, 8'h61);
    b_wr = 1'b1; b_din = 8'h63;
    #3;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("arst_usedw", b_usedw, 0);
    checkOutput("arst_empty", b_empty, 1);
    checkOutput("arst_po", b_dout, 0);
    checkOutput("arst_ae", b_ae, 1);
    checkOutput("arst_small_usedw", s_usedw, 0);
    checkOutput("arst_small_ovf", s_ovf, 0);
    b_wr = 1'b0;
    bq.delete();
    sq.delete();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("post_rst_empty", b_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
